// File: rtl/bus_arbiter_mux_if.sv
// Bus-side signal bundle for bus_arbiter_mux: source data/enables in, registered bus out.
interface bus_arbiter_mux_if #(
    parameter int WIDTH = 9,
    parameter int NSRC  = 10,
    parameter int CNT_W = 8
);
    logic [NSRC*WIDTH-1:0]   src_data;
    logic [NSRC-1:0]         src_sel;
    logic                    clr_cnt;
    logic [WIDTH-1:0]        bus;
    logic                    bus_valid;
    logic [$clog2(NSRC)-1:0] bus_src;
    logic                    conflict;
    logic [CNT_W-1:0]        conflict_cnt;

    // Driver side: presents sources, observes the bus
    modport master (
        output src_data, src_sel, clr_cnt,
        input  bus, bus_valid, bus_src, conflict, conflict_cnt
    );

    // Arbiter side: samples sources, drives the bus
    modport slave (
        input  src_data, src_sel, clr_cnt,
        output bus, bus_valid, bus_src, conflict, conflict_cnt
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered source-select bus with round-robin resolution of multiple enables,
// conflict pulse and saturating conflict counter, optional hold-last-value.
module bus_arbiter_mux #(
    parameter int WIDTH = 9,
    parameter int NSRC  = 10,
    parameter int HOLD  = 0,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              reset,
    bus_arbiter_mux_if.slave io
);
    localparam int SW = $clog2(NSRC);

    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] winner;
    logic          any_sel;
    logic          multi_sel;

    // Round-robin search: first set enable strictly after rr_ptr, wrapping modulo NSRC
    always_comb begin
        int unsigned pos;
        logic        found;
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            pos = (32'(rr_ptr) + k) % NSRC;
            if (!found && io.src_sel[pos[SW-1:0]]) begin
                winner = pos[SW-1:0];
                found  = 1'b1;
            end
        end
        any_sel   = |io.src_sel;
        // Clearing the lowest set bit leaves something only if two or more were set
        multi_sel = |(io.src_sel & (io.src_sel - NSRC'(1)));
    end

    // Bus, grant index, valid/conflict flags and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            io.bus       <= '0;
            io.bus_valid <= 1'b0;
            io.bus_src   <= '0;
            io.conflict  <= 1'b0;
            rr_ptr       <= SW'(NSRC - 1);
        end else if (any_sel) begin
            io.bus       <= io.src_data[32'(winner)*WIDTH +: WIDTH];
            io.bus_valid <= 1'b1;
            io.bus_src   <= winner;
            io.conflict  <= multi_sel;
            rr_ptr       <= winner;
        end else begin
            io.bus_valid <= 1'b0;
            io.conflict  <= 1'b0;
            if (HOLD == 0) begin
                io.bus <= '0;
            end
        end
    end

    // Saturating conflict counter; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || io.clr_cnt) begin
            io.conflict_cnt <= '0;
        end else if (multi_sel && (io.conflict_cnt != '1)) begin
            io.conflict_cnt <= io.conflict_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Self-checking bench: three arbiter variants (default, HOLD=1, CNT_W=2) on shared
// stimulus, compared every cycle against a behavioural model, plus literal checks.
module tb_bus_arbiter_mux;
    localparam int W = 9;
    localparam int N = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] sel = '0;
    logic [N*W-1:0] data = '0;
    logic         clr = 1'b0;
    bit           chk_en = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_arbiter_mux_if #(.WIDTH(W), .NSRC(N), .CNT_W(8)) if0 ();
    bus_arbiter_mux_if #(.WIDTH(W), .NSRC(N), .CNT_W(8)) if1 ();
    bus_arbiter_mux_if #(.WIDTH(W), .NSRC(N), .CNT_W(2)) if2 ();

    assign if0.src_sel = sel;  assign if0.src_data = data;  assign if0.clr_cnt = clr;
    assign if1.src_sel = sel;  assign if1.src_data = data;  assign if1.clr_cnt = clr;
    assign if2.src_sel = sel;  assign if2.src_data = data;  assign if2.clr_cnt = clr;

    bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .HOLD(0), .CNT_W(8)) u0 (.clk(clk), .reset(reset), .io(if0));
    bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .HOLD(1), .CNT_W(8)) u1 (.clk(clk), .reset(reset), .io(if1));
    bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .HOLD(0), .CNT_W(2)) u2 (.clk(clk), .reset(reset), .io(if2));

    typedef struct {
        int bus;
        int valid;
        int src;
        int conf;
        int cnt;
        int rr;
    } mst_t;

    mst_t m0, m1, m2;

    function automatic mst_t mnext(input mst_t s, input int hold, input int cmax,
                                   input logic rst, input logic [N-1:0] se,
                                   input logic [N*W-1:0] d, input logic cl);
        mst_t n;
        int nset;
        int w;
        logic [N*W-1:0] sh;
        n = s;
        if (rst) begin
            n.bus = 0; n.valid = 0; n.src = 0; n.conf = 0; n.cnt = 0; n.rr = N - 1;
            return n;
        end
        nset = $countones(se);
        if (nset == 0) begin
            n.valid = 0;
            n.conf = 0;
            if (hold == 0) n.bus = 0;
        end else begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && se[(s.rr + k) % N]) w = (s.rr + k) % N;
            end
            sh = d >> (w * W);
            n.bus = int'(sh[W-1:0]);
            n.valid = 1;
            n.src = w;
            n.rr = w;
            n.conf = (nset > 1) ? 1 : 0;
            if (nset > 1 && s.cnt < cmax) n.cnt = s.cnt + 1;
        end
        if (cl) n.cnt = 0;
        return n;
    endfunction

    always @(posedge clk) begin
        m0 <= mnext(m0, 0, 255, reset, sel, data, clr);
        m1 <= mnext(m1, 1, 255, reset, sel, data, clr);
        m2 <= mnext(m2, 0, 3,   reset, sel, data, clr);
    end

    task automatic cmp(input string name, input int k, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d] t=%0t got=%0h expected=%0h", name, k, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int k, input mst_t m, input logic [W-1:0] b,
                              input logic v, input logic [3:0] s, input logic c,
                              input logic [7:0] cnt);
        if ($isunknown({b, v, s, c, cnt})) begin
            checks++;
            failures++;
            $display("FAIL xstate[dut%0d] t=%0t got=%0h", k, $time, {b, v, s, c, cnt});
        end else begin
            cmp("bus", k, int'(b), m.bus);
            cmp("bus_valid", k, int'(v), m.valid);
            cmp("bus_src", k, int'(s), m.src);
            cmp("conflict", k, int'(c), m.conf);
            cmp("conflict_cnt", k, int'(cnt), m.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, m0, if0.bus, if0.bus_valid, if0.bus_src, if0.conflict, if0.conflict_cnt);
            check_inst(1, m1, if1.bus, if1.bus_valid, if1.bus_src, if1.conflict, if1.conflict_cnt);
            check_inst(2, m2, if2.bus, if2.bus_valid, if2.bus_src, if2.conflict, {6'b0, if2.conflict_cnt});
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL lit_%s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
    endtask

    initial begin
        // 1: reset then idle
        reset = 1'b1; sel = '0; rand_data();
        step();
        reset = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_data(); step(); end
        lit("idle_bus", int'(if0.bus), 0);
        lit("idle_valid", int'(if0.bus_valid), 0);
        lit("idle_conf", int'(if0.conflict), 0);
        lit("idle_cnt", int'(if0.conflict_cnt), 0);

        // 2: single grant
        rand_data(); data[2*W +: W] = 9'h1A5; sel = 10'h004;
        step();
        lit("single_bus", int'(if0.bus), 'h1A5);
        lit("single_src", int'(if0.bus_src), 2);
        lit("single_valid", int'(if0.bus_valid), 1);
        lit("single_conf", int'(if0.conflict), 0);
        lit("model_pin_bus", m0.bus, 'h1A5);

        // 3: repeated conflict rotates 5,1,5
        sel = 10'h022;
        rand_data(); step();
        lit("rr_src_a", int'(if0.bus_src), 5);
        lit("rr_conf_a", int'(if0.conflict), 1);
        rand_data(); step();
        lit("rr_src_b", int'(if0.bus_src), 1);
        rand_data(); step();
        lit("rr_src_c", int'(if0.bus_src), 5);
        lit("rr_cnt", int'(if0.conflict_cnt), 3);
        lit("model_pin_src", m0.src, 5);

        // 4: hold vs drop-to-zero
        rand_data(); data[0 +: W] = 9'h0AB; sel = 10'h001;
        step();
        sel = '0; rand_data();
        step();
        lit("hold_bus", int'(if1.bus), 'h0AB);
        lit("hold_valid", int'(if1.bus_valid), 0);
        lit("nohold_bus", int'(if0.bus), 0);
        lit("model_pin_hold", m1.bus, 'h0AB);

        // 5: saturation at 3 for CNT_W=2, then clear with same-cycle conflict
        sel = 10'h003;
        for (int i = 0; i < 5; i++) begin rand_data(); step(); end
        lit("sat_cnt", int'(if2.conflict_cnt), 3);
        lit("nosat_cnt", int'(if0.conflict_cnt), 8);
        clr = 1'b1; rand_data();
        step();
        clr = 1'b0;
        lit("clr_cnt", int'(if2.conflict_cnt), 0);
        lit("clr_conf", int'(if2.conflict), 1);

        // 6: reset mid-stream, then wrap search to source 0
        sel = 10'h00C; rand_data(); step();
        reset = 1'b1; rand_data(); step();
        reset = 1'b0;
        lit("rst_bus", int'(if0.bus), 0);
        lit("rst_valid", int'(if0.bus_valid), 0);
        lit("rst_src", int'(if0.bus_src), 0);
        lit("rst_conf", int'(if0.conflict), 0);
        lit("rst_cnt", int'(if0.conflict_cnt), 0);
        sel = 10'h201; rand_data(); step();
        lit("wrap_src", int'(if0.bus_src), 0);
        lit("wrap_conf", int'(if0.conflict), 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            if (mode < 2) sel = '0;
            else if (mode < 5) sel = N'(1) << $urandom_range(0, N - 1);
            else sel = N'($urandom);
            rand_data();
            clr = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; clr = 1'b0; sel = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
